seq_serializer: RTL and testbench

Parallel-to-serial stage that sits directly upstream of the sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a serial data line, with a qualifying valid strobe and an end-of-word marker. Back-to-back words stream with no bubble cycles, so a detector downstream sees patterns that span word boundaries.

---
 rtl/seq_serializer.sv | 86 ++++++++
 tb/tb_seq_serializer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// Parallel-to-serial stage feeding the sequence detectors: WIDTH-bit words in over
// valid/ready, one bit per clock out with valid and end-of-word strobes, no bubbles.
module seq_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data,
  output logic             data_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             data_q, dataValid_q, last_q, busy_q;
  logic             wordEnd, accept, outBit_d;

  assign wordEnd    = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign load_ready = reset & ((state_q == IDLE) | wordEnd);
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    if (accept) begin
      sreg_d  = din;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      if (wordEnd) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      if (LSB_FIRST) sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
      else           sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
    end
  end

  assign outBit_d = LSB_FIRST ? sreg_d[0] : sreg_d[WIDTH-1];

  // Outputs are registered copies of what the next state presents, so the first
  // bit of an accepted word is on data the cycle right after the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sreg_q      <= '0;
      data_q      <= IDLE_BIT;
      dataValid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      data_q      <= (state_d == SHIFT) ? outBit_d : IDLE_BIT;
      dataValid_q <= (state_d == SHIFT);
      last_q      <= (state_d == SHIFT) && (cnt_d == CNT_LAST);
      busy_q      <= (state_d == SHIFT);
    end
  end

  assign data       = data_q;
  assign data_valid = dataValid_q;
  assign last       = last_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: default MSB-first 8-bit instance plus a
// 4-bit LSB-first instance, all expectations hand-derived.
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       loadValid;
  logic       loadReady, dataOut, dataValid, lastOut, busyOut;
  logic [3:0] din4;
  logic       loadValid4;
  logic       loadReady4, dataOut4, dataValid4, lastOut4, busyOut4;

  int testsRun  = 0;
  int testsFail = 0;
  int acceptCount;
  logic [7:0] wordA5;
  logic [7:0] word16;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .load_valid(loadValid),
    .load_ready(loadReady), .data(dataOut), .data_valid(dataValid),
    .last(lastOut), .busy(busyOut)
  );

  seq_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutLsb (
    .clk(clk), .reset(reset), .din(din4), .load_valid(loadValid4),
    .load_ready(loadReady4), .data(dataOut4), .data_valid(dataValid4),
    .last(lastOut4), .busy(busyOut4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] word, input logic valid);
    din       = word;
    loadValid = valid;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    din4       = 4'h0;
    loadValid4 = 1'b0;
    applyStimulus(8'hFF, 1'b1);

    // 1: reset holds everything quiet, even with a word offered
    repeat (3) tick();
    checkOutput("rst data", 32'(dataOut), 32'd0);
    checkOutput("rst valid", 32'(dataValid), 32'd0);
    checkOutput("rst busy", 32'(busyOut), 32'd0);
    checkOutput("rst last", 32'(lastOut), 32'd0);
    checkOutput("rst ready", 32'(loadReady), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel ready", 32'(loadReady), 32'd1);
    checkOutput("rel valid", 32'(dataValid), 32'd0);
    applyStimulus(8'hFF, 1'b0);
    tick();
    checkOutput("rel idle busy", 32'(busyOut), 32'd0);
    checkOutput("rel idle valid", 32'(dataValid), 32'd0);

    // 2: single word 1110_0000
    applyStimulus(8'hE0, 1'b1);
    tick();
    applyStimulus(8'hE0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("w1 data c%0d", i), 32'(dataOut), 32'(i <= 3));
      checkOutput($sformatf("w1 valid c%0d", i), 32'(dataValid), 32'd1);
      checkOutput($sformatf("w1 last c%0d", i), 32'(lastOut), 32'(i == 8));
      checkOutput($sformatf("w1 ready c%0d", i), 32'(loadReady), 32'(i == 8));
      tick();
    end
    checkOutput("w1 c9 valid", 32'(dataValid), 32'd0);
    checkOutput("w1 c9 busy", 32'(busyOut), 32'd0);
    checkOutput("w1 c9 last", 32'(lastOut), 32'd0);

    // 3: back-to-back FF then 0F with load_valid held
    acceptCount = 0;
    applyStimulus(8'hFF, 1'b1);
    if (loadValid && loadReady) acceptCount++;
    tick();
    for (int i = 1; i <= 16; i++) begin
      if (i == 8)  applyStimulus(8'h0F, 1'b1);
      if (i == 16) applyStimulus(8'h0F, 1'b0);
      checkOutput($sformatf("b2b data c%0d", i), 32'(dataOut), 32'((i <= 8) || (i >= 13)));
      checkOutput($sformatf("b2b valid c%0d", i), 32'(dataValid), 32'd1);
      checkOutput($sformatf("b2b last c%0d", i), 32'(lastOut), 32'((i == 8) || (i == 16)));
      if (loadValid && loadReady) acceptCount++;
      tick();
    end
    checkOutput("b2b accepts", 32'(acceptCount), 32'd2);
    checkOutput("b2b c17 valid", 32'(dataValid), 32'd0);

    // 4: A5 with din churn and load_valid pulses while not ready
    wordA5 = 8'hA5;
    applyStimulus(wordA5, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      if (i >= 2 && i <= 6) applyStimulus(8'($urandom), 1'((i % 2) == 0));
      if (i == 7) applyStimulus(8'hC3, 1'b1);
      checkOutput($sformatf("a5 data c%0d", i), 32'(dataOut), 32'(wordA5[8-i]));
      checkOutput($sformatf("a5 ready c%0d", i), 32'(loadReady), 32'(i == 8));
      tick();
    end
    applyStimulus(8'h00, 1'b0);
    checkOutput("a5 next data", 32'(dataOut), 32'd1);
    checkOutput("a5 next valid", 32'(dataValid), 32'd1);
    checkOutput("a5 next last", 32'(lastOut), 32'd0);
    word16 = 8'hC3;
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("c3 data c%0d", i), 32'(dataOut), 32'(word16[8-i]));
      tick();
    end
    checkOutput("c3 drain valid", 32'(dataValid), 32'd0);

    // 5: reset in mid-word, then a fresh word
    applyStimulus(8'hFF, 1'b1);
    tick();
    applyStimulus(8'hFF, 1'b0);
    checkOutput("mid c1 valid", 32'(dataValid), 32'd1);
    tick();
    tick();
    checkOutput("mid c3 valid", 32'(dataValid), 32'd1);
    tick();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid async valid", 32'(dataValid), 32'd0);
    checkOutput("mid async busy", 32'(busyOut), 32'd0);
    checkOutput("mid async data", 32'(dataOut), 32'd0);
    checkOutput("mid async ready", 32'(loadReady), 32'd0);
    #2;
    reset = 1'b1;
    applyStimulus(8'h80, 1'b1);
    tick();
    applyStimulus(8'h00, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("post data c%0d", i), 32'(dataOut), 32'(i == 1));
      checkOutput($sformatf("post last c%0d", i), 32'(lastOut), 32'(i == 8));
      tick();
    end
    checkOutput("post idle valid", 32'(dataValid), 32'd0);

    // 6: LSB-first 4-bit word 0001
    checkOutput("lsb idle ready", 32'(loadReady4), 32'd1);
    din4       = 4'b0001;
    loadValid4 = 1'b1;
    tick();
    loadValid4 = 1'b0;
    din4       = 4'b1110;
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("lsb data c%0d", i), 32'(dataOut4), 32'(i == 1));
      checkOutput($sformatf("lsb valid c%0d", i), 32'(dataValid4), 32'd1);
      checkOutput($sformatf("lsb last c%0d", i), 32'(lastOut4), 32'(i == 4));
      tick();
    end
    checkOutput("lsb idle valid", 32'(dataValid4), 32'd0);
    checkOutput("lsb idle busy", 32'(busyOut4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
